// File: rtl/param_register_file.sv
// Bank of NREG registers sharing one FunSel operation, with per-register enables,
// two combinational read ports and a sticky per-register wrap flag.
module param_register_file #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4,
  localparam int H = WIDTH / 2,
  localparam int S = $clog2(NREG)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [NREG-1:0]  E,
  input  logic [3:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  input  logic [S-1:0]     OutASel,
  input  logic [S-1:0]     OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [NREG-1:0]  Wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]  r_wrap;

  logic [WIDTH-1:0] w_next [NREG];
  logic [NREG-1:0]  w_wrap_next;

  function automatic logic [WIDTH-1:0] f_next(
    input logic [WIDTH-1:0] q,
    input logic [3:0]       fs,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] v;
    v = q;
    case (fs)
      4'b0000: v = q - ONE;
      4'b0001: v = q + ONE;
      4'b0010: v = din;
      4'b0011: v = '0;
      4'b0100: v = {{H{1'b0}}, din[H-1:0]};
      4'b0101: v = {q[WIDTH-1:H], din[H-1:0]};
      4'b0110: v = {din[WIDTH-1:H], q[H-1:0]};
      4'b0111: v = {{H{din[H-1]}}, din[H-1:0]};
      4'b1000: v = {q[WIDTH-2:0], 1'b0};
      4'b1001: v = {1'b0, q[WIDTH-1:1]};
      4'b1010: v = {q[WIDTH-1], q[WIDTH-1:1]};
      4'b1011: v = {q[WIDTH-2:0], q[WIDTH-1]};
      4'b1100: v = {q[0], q[WIDTH-1:1]};
      4'b1101: v = (&q) ? q : q + ONE;
      4'b1110: v = (|q) ? q - ONE : q;
      default: v = q;
    endcase
    return v;
  endfunction

  // Wrap only sets on modular inc/dec crossing the boundary; clear wins only via 0011.
  always_comb begin
    w_wrap_next = r_wrap;
    for (int k = 0; k < NREG; k++) begin
      w_next[k] = f_next(r_regs[k], FunSel, I);
      if (FunSel == 4'b0011)
        w_wrap_next[k] = 1'b0;
      else if ((FunSel == 4'b0001 && (&r_regs[k])) ||
               (FunSel == 4'b0000 && !(|r_regs[k])))
        w_wrap_next[k] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
      r_wrap <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (E[k]) begin
          r_regs[k] <= w_next[k];
          r_wrap[k] <= w_wrap_next[k];
        end
      end
    end
  end

  // Read ports decode explicitly so selects beyond NREG-1 return zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NREG; k++) begin
      if (OutASel == S'(k)) OutA = r_regs[k];
      if (OutBSel == S'(k)) OutB = r_regs[k];
    end
  end

  assign Wrap = r_wrap;

endmodule

// File: tb/tb_param_register_file.sv
// Directed and random checks of param_register_file (WIDTH=16, NREG=4) against an arithmetic model.
module tb_param_register_file;

  logic        Clock;
  logic        Reset;
  logic [3:0]  E;
  logic [3:0]  FunSel;
  logic [15:0] I;
  logic [1:0]  OutASel;
  logic [1:0]  OutBSel;
  logic [15:0] OutA;
  logic [15:0] OutB;
  logic [3:0]  Wrap;

  param_register_file #(.WIDTH(16), .NREG(4)) dut (
    .Clock(Clock), .Reset(Reset), .E(E), .FunSel(FunSel), .I(I),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .Wrap(Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;
  int m_q [4];
  int m_w [4];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int model_op(input int q, input int fs, input int din);
    int lo, hi;
    lo = din % 256;
    hi = din / 256;
    case (fs)
      0:  return (q + 65535) % 65536;
      1:  return (q + 1) % 65536;
      2:  return din;
      3:  return 0;
      4:  return lo;
      5:  return (q / 256) * 256 + lo;
      6:  return hi * 256 + q % 256;
      7:  return lo + ((lo >= 128) ? 65280 : 0);
      8:  return (q * 2) % 65536;
      9:  return q / 2;
      10: return q / 2 + ((q >= 32768) ? 32768 : 0);
      11: return (q * 2) % 65536 + q / 32768;
      12: return q / 2 + (q % 2) * 32768;
      13: return (q == 65535) ? q : q + 1;
      14: return (q == 0) ? q : q - 1;
      default: return q;
    endcase
  endfunction

  task automatic model_edge(input logic [3:0] e, input int fs, input int din);
    for (int k = 0; k < 4; k++) begin
      if (e[k]) begin
        if (fs == 3) m_w[k] = 0;
        else if ((fs == 1 && m_q[k] == 65535) || (fs == 0 && m_q[k] == 0)) m_w[k] = 1;
        m_q[k] = model_op(m_q[k], fs, din);
      end
    end
  endtask

  function automatic logic [3:0] model_wrap();
    logic [3:0] w;
    for (int k = 0; k < 4; k++) w[k] = (m_w[k] != 0);
    return w;
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k);
      OutBSel = 2'(3 - k);
      #1;
      chk($sformatf("%s.A%0d", tag, k), OutA, 16'(m_q[k]));
      chk($sformatf("%s.B%0d", tag, 3 - k), OutB, 16'(m_q[3 - k]));
    end
    chk({tag, ".wrap"}, {12'h0, Wrap}, {12'h0, model_wrap()});
  endtask

  // Apply one operation on the next rising edge, then idle the enables.
  task automatic op(input logic [3:0] e, input logic [3:0] fs, input logic [15:0] din);
    E = e; FunSel = fs; I = din;
    @(posedge Clock);
    model_edge(e, int'(fs), int'(din));
    #1;
    E = 4'b0000;
  endtask

  initial begin
    Reset = 1'b0; E = '0; FunSel = 4'hF; I = '0; OutASel = '0; OutBSel = '0;
    for (int k = 0; k < 4; k++) begin m_q[k] = 0; m_w[k] = 0; end
    #12;
    check_all("reset");
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    // Load and half-load sequence on R0
    op(4'b0001, 4'b0010, 16'h1234); check_all("ld");
    chk("ld.R0", 16'(m_q[0]), 16'h1234);
    op(4'b0001, 4'b0110, 16'hAB00); check_all("ldhi");
    chk("ldhi.R0", 16'(m_q[0]), 16'hAB34);
    op(4'b0001, 4'b0111, 16'h0080); check_all("ldsx");
    chk("ldsx.R0", 16'(m_q[0]), 16'hFF80);
    op(4'b0001, 4'b0100, 16'hFFC5); check_all("ldlo");
    chk("ldlo.R0", 16'(m_q[0]), 16'h00C5);

    // Wrap behaviour on R1
    op(4'b0010, 4'b0010, 16'hFFFF);
    op(4'b0010, 4'b0001, 16'h0000); check_all("wrapinc");
    chk("wrapinc.W", {12'h0, Wrap}, 16'h0002);
    op(4'b0010, 4'b1110, 16'h0000); check_all("satdec");
    chk("satdec.W", {12'h0, Wrap}, 16'h0002);
    op(4'b0010, 4'b0011, 16'h0000); check_all("clr");
    chk("clr.W", {12'h0, Wrap}, 16'h0000);

    // Shifts and rotates on R2 = 0x8001
    op(4'b0100, 4'b0010, 16'h8001); op(4'b0100, 4'b1011, 16'h0); check_all("rol");
    chk("rol.R2", 16'(m_q[2]), 16'h0003);
    op(4'b0100, 4'b0010, 16'h8001); op(4'b0100, 4'b1100, 16'h0); check_all("ror");
    chk("ror.R2", 16'(m_q[2]), 16'hC000);
    op(4'b0100, 4'b0010, 16'h8001); op(4'b0100, 4'b1010, 16'h0); check_all("asr");
    chk("asr.R2", 16'(m_q[2]), 16'hC000);
    op(4'b0100, 4'b0010, 16'h8001); op(4'b0100, 4'b1001, 16'h0); check_all("lsr");
    chk("lsr.R2", 16'(m_q[2]), 16'h4000);

    // Multi-enable decrement
    op(4'b1111, 4'b0011, 16'h0);
    op(4'b0001, 4'b0010, 16'd5);
    op(4'b0010, 4'b0010, 16'hBEEF);
    op(4'b0100, 4'b0010, 16'h0F0F);
    op(4'b1001, 4'b0000, 16'h0); check_all("multi");
    chk("multi.R0", 16'(m_q[0]), 16'd4);
    chk("multi.R3", 16'(m_q[3]), 16'hFFFF);
    chk("multi.W", {12'h0, Wrap}, 16'h0008);

    // Read timing: old value until the edge, new value after
    op(4'b0100, 4'b0010, 16'd7);
    OutASel = 2'd2; OutBSel = 2'd2;
    E = 4'b0100; FunSel = 4'b0010; I = 16'd9;
    @(negedge Clock);
    chk("rt.preA", OutA, 16'd7);
    chk("rt.preB", OutB, 16'd7);
    @(posedge Clock);
    model_edge(4'b0100, 2, 9);
    #1;
    E = 4'b0000;
    chk("rt.postA", OutA, 16'd9);
    chk("rt.postB", OutB, 16'd9);

    // Asynchronous reset between edges
    op(4'b1111, 4'b0010, 16'hFFFF);
    op(4'b1111, 4'b0001, 16'h0);
    op(4'b0001, 4'b0010, 16'h1234);
    chk("prerst.W", {12'h0, Wrap}, 16'h000F);
    E = 4'b1111; FunSel = 4'b0010; I = 16'hAAAA;
    #2;
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin m_q[k] = 0; m_w[k] = 0; end
    #1;
    check_all("arst");
    Reset = 1'b1;
    op(4'b1111, 4'b0001, 16'h0); check_all("postrst");
    chk("postrst.R3", 16'(m_q[3]), 16'd1);

    // Randomised operations against the model
    for (int n = 0; n < 300; n++) begin
      op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
      check_all($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning register width in bits; WIDTH is even and >= 8; H = WIDTH/2.
REQ-002 The block SHALL have parameter NREG, default 4, meaning number of registers (>= 2); S = clog2(NREG).
REQ-003 The block SHALL have port Clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port E, input, NREG bits, per-register write enable; bit k enables register k.
REQ-006 The block SHALL have port FunSel, input, 4 bits, operation applied to every enabled register.
REQ-007 The block SHALL have port I, input, WIDTH bits, load data.
REQ-008 The block SHALL have ports OutASel and OutBSel, input, S bits each, read-port register selects.
REQ-009 The block SHALL have ports OutA and OutB, output, WIDTH bits each, combinational read of the selected register's current (pre-edge) value.
REQ-010 The block SHALL have port Wrap, output, NREG bits, per-register sticky wrap flag.

Function
REQ-011 Each enabled register k SHALL update at the rising Clock edge per FunSel, with Q = current value:
- 0000: Q-1, modulo 2^WIDTH
- 0001: Q+1, modulo 2^WIDTH
- 0010: load I
- 0011: clear to 0
- 0100: load I[H-1:0] into the low half; upper half 0
- 0101: load I[H-1:0] into the low half; upper half held
- 0110: load I[WIDTH-1:H] into the upper half; lower half held
- 0111: load I[H-1:0] into the low half; upper half = I[H-1] replicated (sign-extend)
- 1000: logical shift left 1; LSB 0
- 1001: logical shift right 1; MSB 0
- 1010: arithmetic shift right 1; MSB kept
- 1011: rotate left 1
- 1100: rotate right 1
- 1101: saturating increment; stays at all-ones
- 1110: saturating decrement; stays at 0
- 1111: hold
REQ-012 A register whose E bit is 0 SHALL hold its value and its Wrap bit regardless of FunSel.
REQ-013 Wrap[k] SHALL set at the edge where register k is enabled and either FunSel=0001 with Q = all-ones, or FunSel=0000 with Q = 0.
REQ-014 Wrap[k] SHALL clear only on reset or on an enabled FunSel=0011.
- All other operations, including saturating ops at a limit, leave Wrap[k] unchanged.
REQ-015 Multiple enabled registers SHALL each apply the operation to their own value in the same cycle.
REQ-016 Write latency SHALL be one edge; a read of a register being written SHALL return the old value until after the edge, with no bypass.
REQ-017 OutASel and OutBSel SHALL be independent, and may select the same register.
REQ-018 Out-of-range selects (>= NREG) SHALL drive all zeros.
REQ-019 Arithmetic SHALL be unsigned WIDTH-bit with no carry output; shift and rotate amount is always exactly 1.

Reset
REQ-020 When Reset=0, all registers and all Wrap bits SHALL go to 0 immediately, independent of Clock.
REQ-021 OutA and OutB SHALL therefore read 0 during reset.
REQ-022 Reset asserted mid-sequence SHALL discard any pending operation.
REQ-023 The first operation SHALL occur at the first rising edge after Reset returns to 1.

Verification (WIDTH=16, NREG=4)
REQ-024 The bench SHALL cover the load/half-load sequence on R0:
- E=0001, FunSel=0010, I=0x1234 -> R0=0x1234
- then 0110 with I=0xAB00 -> 0xAB34
- then 0111 with I=0x0080 -> 0xFF80
- then 0100 with I=0xFFC5 -> 0x00C5
REQ-025 The bench SHALL cover wrap behaviour:
- R1=0xFFFF, E=0010, FunSel=0001 -> R1=0x0000, Wrap=0010
- then 1110 -> R1=0x0000, Wrap still 0010
- then 0011 -> Wrap=0000
REQ-026 The bench SHALL cover shifts and rotates on R2=0x8001:
- 1011 -> 0x0003
- 1100 from 0x8001 -> 0xC000
- 1010 from 0x8001 -> 0xC000
- 1001 from 0x8001 -> 0x4000
REQ-027 The bench SHALL cover multi-enable:
- R0=5, R3=0, E=1001, FunSel=0000 -> R0=4, R3=0xFFFF, Wrap=1000
- R1 and R2 unchanged
REQ-028 The bench SHALL cover read timing:
- OutASel=OutBSel=2 with R2=7, then load 9 -> both outputs show 7 before the edge and 9 after it
REQ-029 The bench SHALL cover asynchronous reset:
- Reset=0 between edges with R0=0x1234 and Wrap=1111 -> all registers 0 and Wrap=0000 before the next edge
- first post-release edge with FunSel=0001, E=1111 -> all registers 1
